// File: rtl/my_uart_tx_pkg.sv
// Shared UART definitions: state encoding, baud divider helper and 8N1 frame size.
// Used by both the transmitter and the receiver.
package uart_defs;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // Line bits in a plain 8N1 frame: start + 8 data + 1 stop.
  localparam int FRAME_BITS = 10;

  function automatic int calc_baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/my_uart_tx_baud_gen.sv
// Free-running bit-period counter with synchronous clear and enable.
// Pulses tick for one cycle when the count reaches DIV-1, then wraps to zero.
module uart_baud_gen
  import uart_defs::*;
#(
  parameter int DIV = 434
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   enable,
  output logic                   tick,
  output logic [$clog2(DIV)-1:0] count
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  assign tick = enable && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/my_uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Bytes arrive through a valid/ready handshake; the line output is registered and idles high.
module my_uart_tx
  import uart_defs::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       rs232_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam int CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] STOP_END = CW'(BAUD_DIV - 2);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("my_uart_tx: STOP_BITS must be 1 or 2");
  end
  if (BAUD_DIV < 2) begin : g_bad_baud_div
    $error("my_uart_tx: CLK_FREQ/BAUD must be at least 2");
  end

  logic [2:0]    state;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_idx;
  logic          stop_cnt;
  logic          parity_bit;
  logic          tick;
  logic [CW-1:0] baud_cnt;
  logic          accept;

  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);
  assign accept   = tx_valid && tx_ready;

  uart_baud_gen #(
    .DIV (BAUD_DIV)
  ) u_baud_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .enable (tx_busy),
    .tick   (tick),
    .count  (baud_cnt)
  );

  // The last stop bit leaves STOP one cycle early: its final line cycle is the
  // IDLE/tx_done cycle, so a byte offered then starts with no idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rs232_tx   <= 1'b1;
      tx_done    <= 1'b0;
      shift_reg  <= '0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      parity_bit <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          rs232_tx <= 1'b1;
          if (accept) begin
            shift_reg  <= tx_data;
            parity_bit <= (^tx_data) ^ (PARITY_ODD != 0);
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            rs232_tx   <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (tick) begin
            rs232_tx <= shift_reg[0];
            state    <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shift_reg <= shift_reg >> 1;
            if (bit_idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                rs232_tx <= parity_bit;
                state    <= PARITY;
              end else begin
                rs232_tx <= 1'b1;
                state    <= STOP;
              end
            end else begin
              rs232_tx <= shift_reg[1];
              bit_idx  <= bit_idx + 3'd1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            rs232_tx <= 1'b1;
            state    <= STOP;
          end
        end
        STOP: begin
          if (stop_cnt == 1'(STOP_BITS - 1) && baud_cnt == STOP_END) begin
            state   <= IDLE;
            tx_done <= 1'b1;
          end else if (tick) begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: begin
          rs232_tx <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_my_uart_tx.sv
// Self-checking bench for my_uart_tx: two configurations (8N1 and odd parity with 2 stop bits),
// directed and random bytes compared cycle by cycle against an ideal frame waveform.
module tb_my_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] tx_valid;
  logic [1:0] tx_ready;
  logic [1:0] rs232_tx;
  logic [1:0] tx_busy;
  logic [1:0] tx_done;
  logic [7:0] tx_data [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  my_uart_tx #(
    .CLK_FREQ (1600), .BAUD (100), .PARITY_EN (0), .PARITY_ODD (0), .STOP_BITS (1)
  ) dut0 (
    .clk (clk), .rst_n (rst_n), .tx_data (tx_data[0]), .tx_valid (tx_valid[0]),
    .tx_ready (tx_ready[0]), .rs232_tx (rs232_tx[0]), .tx_busy (tx_busy[0]), .tx_done (tx_done[0])
  );

  my_uart_tx #(
    .CLK_FREQ (700), .BAUD (100), .PARITY_EN (1), .PARITY_ODD (1), .STOP_BITS (2)
  ) dut1 (
    .clk (clk), .rst_n (rst_n), .tx_data (tx_data[1]), .tx_valid (tx_valid[1]),
    .tx_ready (tx_ready[1]), .rs232_tx (rs232_tx[1]), .tx_busy (tx_busy[1]), .tx_done (tx_done[1])
  );

  function automatic int cfgDiv(input int sel);
    return (sel == 0) ? 16 : 7;
  endfunction

  function automatic int cfgParEn(input int sel);
    return (sel == 0) ? 0 : 1;
  endfunction

  function automatic int cfgParOdd(input int sel);
    return (sel == 0) ? 0 : 1;
  endfunction

  function automatic int cfgStops(input int sel);
    return (sel == 0) ? 1 : 2;
  endfunction

  function automatic int frameLen(input int sel);
    return (1 + 8 + cfgParEn(sel) + cfgStops(sel)) * cfgDiv(sel);
  endfunction

  // Ideal level of line bit idx in the frame carrying d.
  function automatic logic expBit(input int sel, input logic [7:0] d, input int idx);
    int ones;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && cfgParEn(sel) != 0) begin
      ones = $countones(d);
      return ((ones % 2) == 1) ? (cfgParOdd(sel) == 0) : (cfgParOdd(sel) != 0);
    end
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Caller is in the low clock phase; the byte is accepted on the next posedge with ready high.
  task automatic applyStimulus(input int sel, input logic [7:0] d);
    bit ok = 0;
    tx_data[sel]  = d;
    tx_valid[sel] = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (tx_ready[sel] === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) checkOutput($sformatf("d%0d_accept_timeout", sel), 0, 1);
  endtask

  task automatic runFrame(input int sel, input logic [7:0] d, input bit noise,
                          input bit nextValid, input logic [7:0] nextData);
    int fl  = frameLen(sel);
    int div = cfgDiv(sel);
    @(posedge clk);
    for (int k = 1; k <= fl; k++) begin
      @(negedge clk);
      checkOutput($sformatf("d%0d_%02h_line_c%0d", sel, d, k), rs232_tx[sel], expBit(sel, d, (k - 1) / div));
      checkOutput($sformatf("d%0d_%02h_done_c%0d", sel, d, k), tx_done[sel], (k == fl));
      if (k == 1 || k == fl - 1 || k == fl) begin
        checkOutput($sformatf("d%0d_%02h_ready_c%0d", sel, d, k), tx_ready[sel], (k == fl));
        checkOutput($sformatf("d%0d_%02h_busy_c%0d", sel, d, k), tx_busy[sel], (k != fl));
      end
      if (k == 1) begin
        tx_valid[sel] = 1'b0;
        tx_data[sel]  = 8'($urandom);
      end else if (noise && k < fl) begin
        tx_valid[sel] = 1'($urandom_range(0, 1));
        tx_data[sel]  = 8'($urandom);
      end
      if (k == fl) begin
        tx_valid[sel] = nextValid;
        tx_data[sel]  = nextData;
      end
    end
  endtask

  task automatic idleCycles(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput($sformatf("d%0d_idle_line", sel), rs232_tx[sel], 1);
      checkOutput($sformatf("d%0d_idle_done", sel), tx_done[sel], 0);
      checkOutput($sformatf("d%0d_idle_ready", sel), tx_ready[sel], 1);
    end
  endtask

  task automatic sendOne(input int sel, input logic [7:0] d, input bit noise);
    applyStimulus(sel, d);
    runFrame(sel, d, noise, 1'b0, 8'h00);
  endtask

  // Pulls reset in the middle of line bit lineBit and checks the frame is dropped cleanly.
  task automatic resetDuring(input int sel, input logic [7:0] d, input int lineBit);
    int div   = cfgDiv(sel);
    int stopK = lineBit * div + div / 2;
    applyStimulus(sel, d);
    @(posedge clk);
    for (int k = 1; k <= stopK; k++) begin
      @(negedge clk);
      checkOutput($sformatf("d%0d_rst_line_c%0d", sel, k), rs232_tx[sel], expBit(sel, d, (k - 1) / div));
      if (k == 1) tx_valid[sel] = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checkOutput($sformatf("d%0d_rst_line_now", sel), rs232_tx[sel], 1);
    checkOutput($sformatf("d%0d_rst_done_now", sel), tx_done[sel], 0);
    checkOutput($sformatf("d%0d_rst_ready_now", sel), tx_ready[sel], 1);
    checkOutput($sformatf("d%0d_rst_busy_now", sel), tx_busy[sel], 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("d%0d_rst_hold_line", sel), rs232_tx[sel], 1);
      checkOutput($sformatf("d%0d_rst_hold_done", sel), tx_done[sel], 0);
    end
    rst_n = 1'b1;
    idleCycles(sel, 2);
  endtask

  initial begin
    logic [7:0] cur;
    logic [7:0] nxt;
    bit         b2b;

    rst_n    = 1'b0;
    tx_valid = '0;
    tx_data[0] = 8'h00;
    tx_data[1] = 8'h00;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checkOutput($sformatf("d%0d_reset_line", s), rs232_tx[s], 1);
      checkOutput($sformatf("d%0d_reset_ready", s), tx_ready[s], 1);
      checkOutput($sformatf("d%0d_reset_busy", s), tx_busy[s], 0);
      checkOutput($sformatf("d%0d_reset_done", s), tx_done[s], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int s = 0; s < 2; s++) begin
      $display("[TB] configuration %0d: divider %0d, frame %0d cycles", s, cfgDiv(s), frameLen(s));
      sendOne(s, 8'h55, 1'b0);
      idleCycles(s, 3);

      applyStimulus(s, 8'hA5);
      runFrame(s, 8'hA5, 1'b0, 1'b1, 8'h3C);
      runFrame(s, 8'h3C, 1'b0, 1'b0, 8'h00);
      idleCycles(s, 3);

      sendOne(s, 8'h81, 1'b1);
      idleCycles(s, 3);

      resetDuring(s, 8'hF0, 4);
      sendOne(s, 8'h00, 1'b0);
      idleCycles(s, 2);

      sendOne(s, 8'h07, 1'b0);
      idleCycles(s, 2);

      cur = 8'($urandom);
      applyStimulus(s, cur);
      for (int i = 0; i < 30; i++) begin
        nxt = 8'($urandom);
        b2b = (i < 29) && ($urandom_range(0, 1) == 1);
        runFrame(s, cur, 1'($urandom_range(0, 1)), b2b, nxt);
        if (i < 29 && !b2b) begin
          idleCycles(s, $urandom_range(1, 4));
          applyStimulus(s, nxt);
        end
        cur = nxt;
      end
      idleCycles(s, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
